ysyx_23060203_alu_arb: RTL and testbench



---
 rtl/ysyx_23060203_alu_arb.sv | 104 ++++++++++
 tb/tb_ysyx_23060203_alu_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered result slot returned on the owner's response port.
module ysyx_23060203_ALU #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct,
  input  logic            sw,
  output logic [XLEN-1:0] val
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SHL = 3'd1, ALU_LTS = 3'd2, ALU_LTU = 3'd3,
                         ALU_XOR = 3'd4, ALU_SHR = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7;

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    val = '0;
    case (funct)
      ALU_ADD: val = sw ? a - b : a + b;
      ALU_SHL: val = a << shamt;
      ALU_LTS: val = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_LTU: val = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR: val = a ^ b;
      ALU_SHR: val = sw ? XLEN'($signed(a) >>> shamt) : a >> shamt;
      ALU_OR:  val = a | b;
      ALU_AND: val = a & b;
      default: val = '0;
    endcase
  end
endmodule

module ysyx_23060203_alu_arb #(
  parameter int       XLEN     = 32,
  parameter bit       RST_PRIO = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [XLEN-1:0] in0_a,
  input  logic [XLEN-1:0] in0_b,
  input  logic [2:0]      in0_funct,
  input  logic            in0_sw,
  input  logic            in1_valid,
  output logic            in1_ready,
  input  logic [XLEN-1:0] in1_a,
  input  logic [XLEN-1:0] in1_b,
  input  logic [2:0]      in1_funct,
  input  logic            in1_sw,
  output logic            out0_valid,
  input  logic            out0_ready,
  output logic [XLEN-1:0] out0_val,
  output logic            out1_valid,
  input  logic            out1_ready,
  output logic [XLEN-1:0] out1_val
);
  logic            res_valid, res_owner, last_grant;
  logic [XLEN-1:0] res_val;
  logic            free, acc0, acc1;
  logic [XLEN-1:0] alu_a, alu_b, alu_val;
  logic [2:0]      alu_funct;
  logic            alu_sw;

  assign free = ~res_valid | (res_owner ? out1_ready : out0_ready);

  // Ready is computed from the other side's valid only, so no requester
  // sees a path from its own valid to its own ready.
  assign in0_ready = ~reset & free & (~in1_valid | last_grant);
  assign in1_ready = ~reset & free & (~in0_valid | ~last_grant);
  assign acc0 = in0_valid & in0_ready;
  assign acc1 = in1_valid & in1_ready;

  assign alu_a     = acc1 ? in1_a     : in0_a;
  assign alu_b     = acc1 ? in1_b     : in0_b;
  assign alu_funct = acc1 ? in1_funct : in0_funct;
  assign alu_sw    = acc1 ? in1_sw    : in0_sw;

  ysyx_23060203_ALU #(.XLEN(XLEN)) u_alu (
    .a(alu_a), .b(alu_b), .funct(alu_funct), .sw(alu_sw), .val(alu_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_owner  <= 1'b0;
      res_val    <= '0;
      last_grant <= ~RST_PRIO;
    end else if (acc0 | acc1) begin
      res_valid  <= 1'b1;
      res_owner  <= acc1;
      res_val    <= alu_val;
      last_grant <= acc1;
    end else if (free) begin
      res_valid  <= 1'b0;
    end
  end

  assign out0_valid = res_valid & ~res_owner;
  assign out1_valid = res_valid &  res_owner;
  assign out0_val   = res_val;
  assign out1_val   = res_val;
endmodule

// File: tb/tb_ysyx_23060203_alu_arb.sv
// Directed plus randomized checks of the shared-ALU arbiter against a
// transaction-level model of the result slot and round-robin turn.
module tb_ysyx_23060203_alu_arb;
  logic        clock = 1'b0, reset = 1'b1;
  logic        in0_valid = 0, in0_ready, in0_sw = 0;
  logic [31:0] in0_a = 0, in0_b = 0;
  logic [2:0]  in0_funct = 0;
  logic        in1_valid = 0, in1_ready, in1_sw = 0;
  logic [31:0] in1_a = 0, in1_b = 0;
  logic [2:0]  in1_funct = 0;
  logic        out0_valid, out0_ready = 0, out1_valid, out1_ready = 0;
  logic [31:0] out0_val, out1_val;

  int n_vec = 0, n_err = 0;
  // model: pending result, its owner, and who was served last
  bit          m_valid, m_owner, m_last;
  logic [31:0] m_val;
  bit          m_acc0, m_acc1;

  always #5 clock = ~clock;

  ysyx_23060203_alu_arb dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
    .in0_funct(in0_funct), .in0_sw(in0_sw),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
    .in1_funct(in1_funct), .in1_sw(in1_sw),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_val(out0_val),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_val(out1_val)
  );

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic sw);
    int sh = int'(b[4:0]);
    longint sa = longint'($signed(a));
    case (f)
      3'd0: return sw ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sw ? 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0))
                      : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_owner = 0; m_last = 1'b1; m_val = 0;
  endtask

  // Called in the low phase with inputs set; checks readies, crosses one
  // rising edge, updates the model, and checks outputs at the next falling edge.
  task automatic tick();
    bit free, g0, g1;
    #1;
    free = !m_valid || (m_owner ? out1_ready : out0_ready);
    g0 = in0_valid && (!in1_valid || m_last);
    g1 = in1_valid && (!in0_valid || !m_last);
    if (in0_valid) chk("in0_ready", 32'(in0_ready), 32'(g0 && free));
    if (in1_valid) chk("in1_ready", 32'(in1_ready), 32'(g1 && free));
    m_acc0 = g0 && free;
    m_acc1 = g1 && free;
    @(posedge clock);
    if (m_acc0 || m_acc1) begin
      m_val   = m_acc1 ? alu_ref(in1_a, in1_b, in1_funct, in1_sw)
                       : alu_ref(in0_a, in0_b, in0_funct, in0_sw);
      m_owner = m_acc1; m_valid = 1; m_last = m_acc1;
    end else if (free) m_valid = 0;
    @(negedge clock);
    chk("out0_valid", 32'(out0_valid), 32'(m_valid && !m_owner));
    chk("out1_valid", 32'(out1_valid), 32'(m_valid && m_owner));
    if (m_valid) chk(m_owner ? "out1_val" : "out0_val", m_owner ? out1_val : out0_val, m_val);
  endtask

  task automatic set0(bit v, logic [31:0] a, logic [31:0] b, logic [2:0] f, bit sw);
    in0_valid = v; in0_a = a; in0_b = b; in0_funct = f; in0_sw = sw;
  endtask
  task automatic set1(bit v, logic [31:0] a, logic [31:0] b, logic [2:0] f, bit sw);
    in1_valid = v; in1_a = a; in1_b = b; in1_funct = f; in1_sw = sw;
  endtask

  initial begin
    int wait_n;
    logic [31:0] held;
    model_reset();
    #2;
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out0_val", out0_val, 0);
    chk("rst_in0_ready", 32'(in0_ready), 0);
    chk("rst_in1_ready", 32'(in1_ready), 0);
    @(negedge clock); @(negedge clock);
    reset = 0;

    // in0 alone: ADD 5+3, then drain
    out0_ready = 1; out1_ready = 1;
    set0(1, 5, 3, 3'd0, 0); tick();
    chk("add_val", out0_val, 32'd8);
    set0(0, 0, 0, 0, 0); tick();
    chk("drained", 32'(out0_valid | out1_valid), 0);

    // in1 alone: SUB, LTS, LTU, SRA
    set1(1, 10, 3, 3'd0, 1); tick(); chk("sub_val", out1_val, 32'd7);
    set1(1, 32'hFFFF_FFFF, 1, 3'd2, 0); tick(); chk("lts_val", out1_val, 32'd1);
    set1(1, 32'hFFFF_FFFF, 1, 3'd3, 0); tick(); chk("ltu_val", out1_val, 32'd0);
    set1(1, 32'h8000_0000, 4, 3'd5, 1); tick(); chk("sra_val", out1_val, 32'hF800_0000);
    set1(0, 0, 0, 0, 0); tick();

    // both valid, alternating grants
    for (int i = 0; i < 6; i++) begin
      set0(1, 32'(i), 100, 3'd0, 0); set1(1, 32'(i), 200, 3'd0, 0);
      tick();
      chk("alt_owner", 32'(out1_valid), 32'(m_last));
    end

    // owner stall: in0 owns result, out0_ready low for 3 cycles
    set1(0, 0, 0, 0, 0); set0(1, 7, 7, 3'd6, 0); tick();
    while (!out0_valid) tick();
    set0(1, 1, 2, 3'd4, 0); set1(1, 3, 4, 3'd4, 0);
    out0_ready = 0;
    held = out0_val;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rdy", 32'({in0_ready, in1_ready}), 0);
      chk("stall_hold", out0_val, held);
    end
    out0_ready = 1; #1;
    chk("drain_acc_in1", 32'({in0_ready, in1_ready}), 32'b01);
    tick();
    chk("drain_acc_owner", 32'(out1_valid), 1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick();

    // reset while a SHL result is held
    out0_ready = 0;
    set0(1, 7, 1, 3'd1, 0); tick();
    chk("shl_val", out0_val, 32'd14);
    set0(0, 0, 0, 0, 0);
    #2 reset = 1; #1;
    chk("arst_out0_valid", 32'(out0_valid), 0);
    chk("arst_in_ready", 32'({in0_ready, in1_ready}), 0);
    model_reset();
    @(negedge clock); reset = 0; out0_ready = 1;
    tick();
    chk("no_stale", 32'(out0_valid | out1_valid), 0);
    set0(1, 1, 1, 3'd0, 0); set1(1, 2, 2, 3'd0, 0); tick();
    chk("post_rst_prio", 32'(out0_valid), 1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick();

    // in0 always valid, in1 held: in1 must win within two cycles
    set0(1, 9, 9, 3'd7, 0); tick();
    set1(1, 5, 6, 3'd6, 0);
    wait_n = 0;
    while (!m_acc1 && wait_n < 2) begin tick(); wait_n++; end
    chk("no_starve", 32'(m_acc1), 1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick();

    // randomized traffic, payload held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!in0_valid || m_acc0)
        set0($urandom_range(0, 1), $urandom, $urandom, 3'($urandom), 1'($urandom));
      if (!in1_valid || m_acc1)
        set1($urandom_range(0, 1), $urandom, $urandom, 3'($urandom), 1'($urandom));
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
